// File: rtl/piso_tx_if.sv
// Handshake bundle for piso_tx: parallel word in, serial bit stream out.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_ready;
  logic             busy;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word and emits it one
// bit per accepted serial beat, MSB or LSB first, with ser_last on the final bit.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus,
  output logic     state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             beat;
  logic             last;
  logic             accept;

  assign state_dbg = state;

  // Outputs decode straight from registered state, so ser_out never depends on ser_ready.
  always_comb begin
    bus.ser_valid = (state == SHIFT);
    bus.busy      = (state == SHIFT);
    last          = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    bus.ser_last  = last;
    bus.ser_out   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    beat          = bus.ser_valid && bus.ser_ready;
    bus.in_ready  = rst && ((state == IDLE) || (beat && last));
    accept        = bus.in_valid && bus.in_ready;
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nx = bus.in_data;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          shreg_nx = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          cnt_nx   = cnt + CW'(1);
          // Last beat either chains straight into the next word or returns to IDLE.
          if (last) begin
            if (accept) begin
              shreg_nx = bus.in_data;
              cnt_nx   = '0;
            end else begin
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share one stimulus stream,
// checked against a word-queue model plus a directed vector table and corner sequences.
module tb_piso_tx;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             ser_ready;
  logic             dbg_m, dbg_l;

  piso_tx_if #(.WIDTH(WIDTH)) ifm ();
  piso_tx_if #(.WIDTH(WIDTH)) ifl ();

  assign ifm.in_data   = in_data;
  assign ifm.in_valid  = in_valid;
  assign ifm.ser_ready = ser_ready;
  assign ifl.in_data   = in_data;
  assign ifl.in_valid  = in_valid;
  assign ifl.ser_ready = ser_ready;

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(ifm.slave), .state_dbg(dbg_m)
  );
  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(ifl.slave), .state_dbg(dbg_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: queue of accepted words plus how many bits of the head word were sent.
  logic [WIDTH-1:0] exp_q[$];
  int               pos = 0;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             sr;
    logic             rdy;
    logic             vld;
    logic             out;
    logic             last;
  } vec_t;

  vec_t vecs[32];
  int   nvec = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic iv, input logic [WIDTH-1:0] d, input logic sr,
                         input logic rdy, input logic vld, input logic out, input logic last);
    vecs[nvec] = '{iv: iv, d: d, sr: sr, rdy: rdy, vld: vld, out: out, last: last};
    nvec++;
  endtask

  // Drive one cycle at the falling edge, check both DUTs against the model, then advance the model.
  task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic sr);
    logic             exp_vld, exp_rdy, exp_last;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    ser_ready = sr;
    #1;
    exp_vld  = (exp_q.size() != 0);
    exp_last = exp_vld && (pos == WIDTH - 1);
    exp_rdy  = !exp_vld || (sr && exp_last);
    chk("m_in_ready", ifm.in_ready, exp_rdy);
    chk("l_in_ready", ifl.in_ready, exp_rdy);
    chk("m_ser_valid", ifm.ser_valid, exp_vld);
    chk("l_ser_valid", ifl.ser_valid, exp_vld);
    chk("m_busy", ifm.busy, exp_vld);
    chk("l_busy", ifl.busy, exp_vld);
    chk("m_ser_last", ifm.ser_last, exp_last);
    chk("l_ser_last", ifl.ser_last, exp_last);
    if (exp_vld) begin
      w = exp_q[0];
      chk("m_ser_out", ifm.ser_out, w[WIDTH-1-pos]);
      chk("l_ser_out", ifl.ser_out, w[pos]);
    end
    if (exp_vld && sr) begin
      pos++;
      if (pos == WIDTH) begin
        void'(exp_q.pop_front());
        pos = 0;
      end
    end
    if (iv && exp_rdy) exp_q.push_back(d);
  endtask

  logic [WIDTH-1:0] seq, lastseq;

  initial begin
    in_valid  = 1'b1;
    in_data   = 4'hF;
    ser_ready = 1'b1;

    // Reset held with in_valid high: nothing may be offered or accepted.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_m_in_ready", ifm.in_ready, 1'b0);
      chk("rst_l_in_ready", ifl.in_ready, 1'b0);
      chk("rst_m_ser_valid", ifm.ser_valid, 1'b0);
      chk("rst_m_busy", ifm.busy, 1'b0);
      chk("rst_m_ser_last", ifm.ser_last, 1'b0);
      chk("rst_m_ser_out", ifm.ser_out, 1'b0);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_m_in_ready", ifm.in_ready, 1'b1);
    chk("rel_m_ser_valid", ifm.ser_valid, 1'b0);

    // Directed table (MSB-first instance): single word, back-to-back, backpressure.
    //       iv    d      sr    rdy   vld   out   last
    add_vec(1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].sr);
      chk($sformatf("vec%0d_in_ready", i), ifm.in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_ser_valid", i), ifm.ser_valid, vecs[i].vld);
      chk($sformatf("vec%0d_ser_last", i), ifm.ser_last, vecs[i].last);
      if (vecs[i].vld) chk($sformatf("vec%0d_ser_out", i), ifm.ser_out, vecs[i].out);
    end

    // LSB-first instance: 4'b0001 must come out as 1,0,0,0 with last on beat 4.
    step(1'b1, 4'b0001, 1'b1);
    seq = '0;
    lastseq = '0;
    for (int b = 0; b < WIDTH; b++) begin
      step(1'b0, 4'h0, 1'b1);
      seq     = {seq[WIDTH-2:0], ifl.ser_out};
      lastseq = {lastseq[WIDTH-2:0], ifl.ser_last};
    end
    chk_vec("lsb_bits", seq, 4'b1000);
    chk_vec("lsb_last", lastseq, 4'b0001);
    step(1'b0, 4'h0, 1'b1);

    // Reset in the middle of 4'hF, then 4'h9 must come out clean.
    step(1'b1, 4'hF, 1'b1);
    step(1'b0, 4'hF, 1'b1);
    step(1'b0, 4'hF, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_m_ser_valid", ifm.ser_valid, 1'b0);
    chk("midrst_l_ser_valid", ifl.ser_valid, 1'b0);
    chk("midrst_m_busy", ifm.busy, 1'b0);
    chk("midrst_m_in_ready", ifm.in_ready, 1'b0);
    exp_q.delete();
    pos = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'h9, 1'b1);
    seq = '0;
    for (int b = 0; b < WIDTH; b++) begin
      step(1'b0, 4'h0, 1'b1);
      seq = {seq[WIDTH-2:0], ifm.ser_out};
    end
    chk_vec("midrst_next_bits", seq, 4'b1001);
    step(1'b0, 4'h0, 1'b1);

    // Random traffic with backpressure, both bit orders checked against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1), WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
           ($urandom_range(0, 9) < 7));
    end
    // Drain so every accepted word is fully observed.
    for (int i = 0; i < 4 * WIDTH; i++) step(1'b0, 4'h0, 1'b1);
    chk("drained", (exp_q.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter, the serialising counterpart to the team's parallel register and deserialiser paths.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per accepted serial beat.
- The serial side has its own valid/ready/last handshake, so a downstream receiver can apply backpressure.
- Sits between a parallel datapath register stage and a serial link or downstream SIPO receiver.

Parameters:
WIDTH, 4, bits per word; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
in_data  input  WIDTH  parallel word; sampled only on acceptance.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word this cycle.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out is valid.
ser_last  output  1  ser_out is the final bit of the word.
ser_ready  input  1  downstream accepts ser_out this cycle.
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst).
- Reset (rst low):
  - State = IDLE; shift register, bit counter, ser_out, ser_valid, ser_last and busy all 0.
  - in_ready is forced 0 while rst is low.
- States:
  - IDLE: ser_valid = 0, in_ready = 1.
  - SHIFT: ser_valid = 1, busy = 1.
- Input acceptance:
  - Accept when in_valid && in_ready.
  - On the next edge: shift register <= in_data, counter <= 0, state <= SHIFT.
  - Latency: the first serial bit is valid 1 cycle after acceptance.
- in_ready is combinational: (state == IDLE) || (ser_valid && ser_ready && ser_last). This gives back-to-back words with no bubble.
- ser_out:
  - MSB_FIRST = 1: ser_out = shreg[WIDTH-1].
  - MSB_FIRST = 0: ser_out = shreg[0].
  - ser_out is registered-stable and does not depend on ser_ready.
- Serial beat: a beat completes when ser_valid && ser_ready. On each beat:
  - The register shifts toward the output end with 0 fill.
  - The counter increments.
- Stall: while ser_valid && !ser_ready, ser_out, the counter and ser_last hold unchanged for any number of cycles.
- Counter and ser_last:
  - Counter width is $clog2(WIDTH).
  - ser_last = ser_valid && (counter == WIDTH-1).
- Word end: on the beat where ser_last = 1:
  - If in_valid = 1, load the new word, counter <= 0, stay in SHIFT (ser_valid remains 1).
  - Otherwise state <= IDLE, ser_valid <= 0, busy <= 0.
- Ignored inputs:
  - in_data changes after acceptance have no effect.
  - in_valid during SHIFT (other than on the last beat) is ignored and is not acknowledged.
- ser_ready is ignored in IDLE.
- Reset mid-word: all outputs clear immediately. The partial word is discarded, not resumed. The next accepted word starts at bit 0 of the serial order.
- Exactly WIDTH beats are emitted per accepted word, never more or fewer.

Test Plan:
1. Reset: hold rst low with in_valid = 1 -> in_ready = 0, ser_valid = 0, busy = 0. Release rst -> in_ready = 1 the next cycle; no word accepted before release.
2. Single word (WIDTH = 4, MSB_FIRST = 1), in_data = 4'b1011, ser_ready = 1 -> ser_out = 1,0,1,1 on cycles 1-4 after accept; ser_last only on cycle 4; busy drops and in_ready = 1 on cycle 5.
3. Back-to-back: 4'hA then 4'h5 with in_valid held and ser_ready = 1 -> 8 contiguous beats 1,0,1,0,0,1,0,1; ser_valid never drops; in_ready high only on the first word's last beat; ser_last on beats 4 and 8.
4. Backpressure: 4'b1100, ser_ready = 0 for 3 cycles while bit 2 is presented -> ser_out holds 0 throughout the stall; ser_last not asserted early; exactly 4 accepted beats 1,1,0,0.
5. LSB-first (MSB_FIRST = 0): in_data = 4'b0001 -> ser_out = 1,0,0,0 with ser_last on beat 4.
6. Reset mid-word: assert rst after 2 beats of 4'hF -> ser_valid = 0 immediately. After release, send 4'h9 -> 1,0,0,1 with no leftover bits from 4'hF.
